// File: rtl/btn_conditioner.sv
//-----------------------------------------------------------------------------
// btn_conditioner
//
// Input conditioning for active-low board push-buttons. Each channel runs its
// raw pin through a two-flop synchronizer and a counter-based debounce FSM,
// then produces a clean active-high level plus one-cycle press and release
// pulses. All outputs are registered. Channels are completely independent.
//
// Parameters:
//   NUM_BTN         - number of button channels
//   DEBOUNCE_CYCLES - consecutive stable synchronized samples needed to
//                     commit a level change (>= 2)
//
// Ports:
//   sys_clk     in   system clock, rising edge
//   sys_rst_n   in   asynchronous active-low reset
//   sys_btn     in   raw button pins, active-low, asynchronous to sys_clk
//   btn_level   out  debounced level, 1 = pressed
//   btn_press   out  one-cycle pulse on the rising edge of btn_level
//   btn_release out  one-cycle pulse on the falling edge of btn_level
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module btn_conditioner #(
  parameter int NUM_BTN         = 2,
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [NUM_BTN-1:0] sys_btn,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  // Counter width is derived; the largest value ever held is DEBOUNCE_CYCLES-1,
  // which always fits in $clog2(DEBOUNCE_CYCLES) bits.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_WAIT_PRESS   = 2'd1,
    ST_HELD         = 2'd2,
    ST_WAIT_RELEASE = 2'd3
  } state_t;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_ch

      // Synchronizer flops reset to 1 so a reset looks like "released".
      logic r_sync1;
      logic r_sync2;
      // Synchronized sample, active-high (1 = pressed).
      logic w_sample;

      state_t           r_state;
      state_t           w_state_next;
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] w_cnt_next;
      logic             w_cnt_last;

      logic r_level;
      logic r_press;
      logic r_release;
      logic w_level_next;
      logic w_press_next;
      logic w_release_next;

      //-----------------------------------------------------------------------
      // Two-flop synchronizer for the asynchronous pin.
      //-----------------------------------------------------------------------
      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
          r_sync1 <= 1'b1;
          r_sync2 <= 1'b1;
        end else begin
          r_sync1 <= sys_btn[gi];
          r_sync2 <= r_sync1;
        end
      end

      assign w_sample   = ~r_sync2;
      assign w_cnt_last = (r_cnt == CNT_LAST);

      //-----------------------------------------------------------------------
      // State register: FSM state, debounce counter and registered outputs.
      //-----------------------------------------------------------------------
      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
          r_state   <= ST_RELEASED;
          r_cnt     <= '0;
          r_level   <= 1'b0;
          r_press   <= 1'b0;
          r_release <= 1'b0;
        end else begin
          r_state   <= w_state_next;
          r_cnt     <= w_cnt_next;
          r_level   <= w_level_next;
          r_press   <= w_press_next;
          r_release <= w_release_next;
        end
      end

      //-----------------------------------------------------------------------
      // Next-state logic. The counter defaults to zero so that every abort
      // and every commit restarts the count; it only advances while a
      // candidate change keeps being confirmed.
      //-----------------------------------------------------------------------
      always_comb begin
        w_state_next = r_state;
        w_cnt_next   = '0;
        case (r_state)
          ST_RELEASED: begin
            // The first differing sample already counts as one.
            if (w_sample) begin
              w_state_next = ST_WAIT_PRESS;
              w_cnt_next   = CNT_ONE;
            end
          end
          ST_WAIT_PRESS: begin
            if (!w_sample) begin
              w_state_next = ST_RELEASED;
            end else if (w_cnt_last) begin
              w_state_next = ST_HELD;
            end else begin
              w_cnt_next = r_cnt + CNT_ONE;
            end
          end
          ST_HELD: begin
            if (!w_sample) begin
              w_state_next = ST_WAIT_RELEASE;
              w_cnt_next   = CNT_ONE;
            end
          end
          ST_WAIT_RELEASE: begin
            if (w_sample) begin
              w_state_next = ST_HELD;
            end else if (w_cnt_last) begin
              w_state_next = ST_RELEASED;
            end else begin
              w_cnt_next = r_cnt + CNT_ONE;
            end
          end
          default: begin
            w_state_next = ST_RELEASED;
          end
        endcase
      end

      //-----------------------------------------------------------------------
      // Output logic. Pulses fire only on the commit transition, so they are
      // high for exactly one cycle and press/release are mutually exclusive
      // (they come from different states).
      //-----------------------------------------------------------------------
      always_comb begin
        w_press_next   = (r_state == ST_WAIT_PRESS)   &&  w_sample && w_cnt_last;
        w_release_next = (r_state == ST_WAIT_RELEASE) && !w_sample && w_cnt_last;
        w_level_next   = r_level;
        if (w_press_next) begin
          w_level_next = 1'b1;
        end else if (w_release_next) begin
          w_level_next = 1'b0;
        end
      end

      assign btn_level[gi]   = r_level;
      assign btn_press[gi]   = r_press;
      assign btn_release[gi] = r_release;

    end
  endgenerate

endmodule

// File: tb/tb_btn_conditioner.sv
`timescale 1ns/1ps

module tb_btn_conditioner;

  localparam int DA = 4;   // short debounce, two-channel instance
  localparam int DB = 37;  // longer debounce, one-channel instance

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] btn_a;
  logic [0:0] btn_b;
  logic [1:0] lvl_a, prs_a, rel_a;
  logic [0:0] lvl_b, prs_b, rel_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  btn_conditioner #(.NUM_BTN(2), .DEBOUNCE_CYCLES(DA)) dut_a (
    .sys_clk(clk), .sys_rst_n(rst_n), .sys_btn(btn_a),
    .btn_level(lvl_a), .btn_press(prs_a), .btn_release(rel_a)
  );

  btn_conditioner #(.NUM_BTN(1), .DEBOUNCE_CYCLES(DB)) dut_b (
    .sys_clk(clk), .sys_rst_n(rst_n), .sys_btn(btn_b),
    .btn_level(lvl_b), .btn_press(prs_b), .btn_release(rel_b)
  );

  // Reference model: channels 0,1 -> dut_a, channel 2 -> dut_b.
  // A change commits after lim consecutive synchronized samples that differ
  // from the current stable level; the pin reaches the decision 2 edges late.
  logic m_d1  [3];
  logic m_d2  [3];
  int   m_run [3];
  logic m_lvl [3];
  logic m_prs [3];
  logic m_rel [3];

  function automatic logic pin_of(int ch);
    return (ch < 2) ? btn_a[ch] : btn_b[0];
  endfunction

  function automatic int lim_of(int ch);
    return (ch < 2) ? DA : DB;
  endfunction

  function automatic logic [8:0] obs_all();
    return {rel_b[0], prs_b[0], lvl_b[0],
            rel_a[1], prs_a[1], lvl_a[1],
            rel_a[0], prs_a[0], lvl_a[0]};
  endfunction

  function automatic logic [8:0] exp_all();
    logic [8:0] e;
    for (int ch = 0; ch < 3; ch++) e[3*ch +: 3] = {m_rel[ch], m_prs[ch], m_lvl[ch]};
    return e;
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < 3; ch++) begin
      m_d1[ch] = 1'b1; m_d2[ch] = 1'b1; m_run[ch] = 0;
      m_lvl[ch] = 1'b0; m_prs[ch] = 1'b0; m_rel[ch] = 1'b0;
    end
  endtask

  // One rising edge with the pins set beforehand; returns at the next falling edge.
  task automatic tick();
    @(posedge clk);
    for (int ch = 0; ch < 3; ch++) begin
      logic pressed;
      pressed   = ~m_d2[ch];
      m_d2[ch]  = m_d1[ch];
      m_d1[ch]  = pin_of(ch);
      m_prs[ch] = 1'b0;
      m_rel[ch] = 1'b0;
      if (pressed != m_lvl[ch]) begin
        m_run[ch]++;
        if (m_run[ch] == lim_of(ch)) begin
          m_lvl[ch] = pressed;
          if (pressed) m_prs[ch] = 1'b1; else m_rel[ch] = 1'b1;
          m_run[ch] = 0;
        end
      end else begin
        m_run[ch] = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    btn_a = 2'b11;
    btn_b = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if (obs_all() !== 9'd0) begin
      bad++; $display("FAIL reset_state got=%b want=%b", obs_all(), 9'd0);
    end
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      tick();
      total++;
      if (obs_all() !== 9'd0) begin
        bad++; $display("FAIL reset_idle k=%0d got=%b want=%b", k, obs_all(), 9'd0);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_press_latency();
    logic [3:0] got, want;
    apply_reset();
    btn_a[0] = 1'b0;  // before E0
    for (int k = 0; k < 10; k++) begin
      tick();
      got  = {lvl_a[0], prs_a[0], rel_a[0], lvl_a[1]};
      want = {(k >= 5), (k == 5), 1'b0, 1'b0};
      total++;
      if (got !== want) begin
        bad++; $display("FAIL press_latency k=%0d got=%b want=%b", k, got, want);
      end
      total++;
      if (obs_all() !== exp_all()) begin
        bad++; $display("FAIL press_model k=%0d got=%b want=%b", k, obs_all(), exp_all());
      end
    end
    btn_a[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      got  = {lvl_a[0], prs_a[0], rel_a[0], lvl_a[1]};
      want = {(k < 5), 1'b0, (k == 5), 1'b0};
      total++;
      if (got !== want) begin
        bad++; $display("FAIL release_latency k=%0d got=%b want=%b", k, got, want);
      end
    end
    $display("test_press_latency done");
  endtask

  task automatic test_glitch();
    apply_reset();
    for (int k = 0; k < 12; k++) begin
      btn_a[0] = (k < 3) ? 1'b0 : 1'b1;
      tick();
      total++;
      if (obs_all() !== 9'd0 || exp_all() !== 9'd0) begin
        bad++; $display("FAIL glitch k=%0d got=%b model=%b want=%b", k, obs_all(), exp_all(), 9'd0);
      end
    end
    $display("test_glitch done");
  endtask

  task automatic test_bounce();
    logic pat [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int rise_k = -1;
    int presses = 0;
    apply_reset();
    for (int k = 0; k < 16; k++) begin
      btn_a[0] = (k < 5) ? pat[k] : 1'b0;
      tick();
      if (prs_a[0]) presses++;
      if (lvl_a[0] && rise_k < 0) rise_k = k;
      total++;
      if (obs_all() !== exp_all()) begin
        bad++; $display("FAIL bounce_model k=%0d got=%b want=%b", k, obs_all(), exp_all());
      end
    end
    total++;
    if (rise_k != 10) begin
      bad++; $display("FAIL bounce_rise got=%0d want=%0d", rise_k, 10);
    end
    total++;
    if (presses != 1) begin
      bad++; $display("FAIL bounce_presses got=%0d want=%0d", presses, 1);
    end
    $display("test_bounce done rise=%0d presses=%0d", rise_k, presses);
  endtask

  task automatic test_simultaneous();
    int rise [2] = '{-1, -1};
    int fall [2] = '{-1, -1};
    int np   [2] = '{0, 0};
    int nr   [2] = '{0, 0};
    apply_reset();
    for (int k = 0; k < 35; k++) begin
      btn_a = (k < 20) ? 2'b00 : 2'b11;
      tick();
      for (int ch = 0; ch < 2; ch++) begin
        if (prs_a[ch]) begin np[ch]++; if (rise[ch] < 0) rise[ch] = k; end
        if (rel_a[ch]) begin nr[ch]++; if (fall[ch] < 0) fall[ch] = k; end
        total++;
        if (prs_a[ch] && rel_a[ch]) begin
          bad++; $display("FAIL simul_exclusive ch=%0d k=%0d got=11 want=not_both", ch, k);
        end
      end
    end
    for (int ch = 0; ch < 2; ch++) begin
      total++;
      if (rise[ch] != 5 || fall[ch] != 25) begin
        bad++; $display("FAIL simul_edges ch=%0d got=%0d/%0d want=5/25", ch, rise[ch], fall[ch]);
      end
      total++;
      if (np[ch] != 1 || nr[ch] != 1) begin
        bad++; $display("FAIL simul_pulses ch=%0d got=%0d/%0d want=1/1", ch, np[ch], nr[ch]);
      end
    end
    $display("test_simultaneous done rise=%0d,%0d fall=%0d,%0d", rise[0], rise[1], fall[0], fall[1]);
  endtask

  task automatic test_reset_mid();
    logic [3:0] got, want;
    int pulses = 0;
    apply_reset();
    btn_a[1] = 1'b0;
    repeat (7) tick();
    btn_a[0] = 1'b0;
    repeat (3) tick();  // ch0 now mid-debounce, ch1 held
    total++;
    if (lvl_a !== 2'b10 || obs_all() !== exp_all()) begin
      bad++; $display("FAIL pre_reset got=%b want=%b", obs_all(), exp_all());
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (obs_all() !== 9'd0) begin
      bad++; $display("FAIL async_reset got=%b want=%b", obs_all(), 9'd0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      pulses += int'(prs_a[0]) + int'(prs_a[1]) + int'(rel_a[0]) + int'(rel_a[1]);
      got  = {lvl_a[0], prs_a[0], lvl_a[1], prs_a[1]};
      want = {(k >= 5), (k == 5), (k >= 5), (k == 5)};
      total++;
      if (got !== want) begin
        bad++; $display("FAIL redetect k=%0d got=%b want=%b", k, got, want);
      end
    end
    total++;
    if (pulses != 2) begin
      bad++; $display("FAIL redetect_pulses got=%0d want=%0d", pulses, 2);
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_long_hold();
    int rise_k = -1;
    int fall_k = -1;
    int np = 0;
    int nr = 0;
    apply_reset();
    for (int k = 0; k < 260; k++) begin
      btn_b[0] = (k < 200) ? 1'b0 : 1'b1;
      tick();
      if (prs_b[0]) begin np++; if (rise_k < 0) rise_k = k; end
      if (rel_b[0]) begin nr++; if (fall_k < 0) fall_k = k; end
    end
    total++;
    if (rise_k != DB + 1 || fall_k != 200 + DB + 1) begin
      bad++; $display("FAIL long_hold_edges got=%0d/%0d want=%0d/%0d", rise_k, fall_k, DB + 1, 200 + DB + 1);
    end
    total++;
    if (np != 1 || nr != 1) begin
      bad++; $display("FAIL long_hold_pulses got=%0d/%0d want=1/1", np, nr);
    end
    $display("test_long_hold done rise=%0d fall=%0d", rise_k, fall_k);
  endtask

  task automatic test_random();
    int remain [3] = '{0, 0, 0};
    int errs = 0;
    apply_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int ch = 0; ch < 3; ch++) begin
        if (remain[ch] == 0) begin
          if (ch < 2) begin
            btn_a[ch] = ~btn_a[ch];
            remain[ch] = int'($urandom_range(1, 9));
          end else begin
            btn_b[0] = ~btn_b[0];
            remain[ch] = int'($urandom_range(1, 80));
          end
        end
        remain[ch]--;
      end
      tick();
      total++;
      if (obs_all() !== exp_all()) begin
        bad++; errs++;
        if (errs < 20) $display("FAIL random_model cyc=%0d got=%b want=%b", cyc, obs_all(), exp_all());
      end
      total++;
      if (((prs_a & rel_a) != 2'b00) || ((prs_b & rel_b) != 1'b0)) begin
        bad++; $display("FAIL random_exclusive cyc=%0d got=%b want=no_overlap", cyc, obs_all());
      end
    end
    $display("test_random done");
  endtask

  initial begin
    rst_n = 1'b0;
    btn_a = 2'b11;
    btn_b = 1'b1;
    model_reset();
    test_reset();
    test_press_latency();
    test_glitch();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    test_long_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
